// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: shared definitions for the ALU issue/collect sequencer.
//   seq_state_t : sequencer FSM encoding (binary, 3 bits)
//   F3_*        : RV funct3 codes seen by the ALU
//   F7_*        : RV funct7 codes (base, alternate SUB/SRA, M-extension)
package alu_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_COLLECT = 3'd3,
    S_DRAIN   = 3'd4
  } seq_state_t;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: flags ops that run on the ALU's iterative unit
// (shifts, and MUL/DIV from the register form of OP).
// Ports:
//   funct3, funct7, imm : op fields
//   is_iterative        : 1 when the ALU will raise busy for this op
module alu_seq_decode
  import alu_sequencer_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       imm,
  output logic       is_iterative
);

  // M-extension only exists in register form; with imm=1 funct7 is part of
  // the immediate, so it must not be decoded as MUL/DIV.
  assign is_iterative = ((funct7 == F7_MULDIV) && !imm) ||
                        (funct3 == F3_SLL) || (funct3 == F3_SR);

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: execute-stage issue/collect controller for the ALU.
// Accepts one op per valid/ready handshake, presents it to the ALU, waits out
// the iterative unit's busy, and returns the result in a registered response.
//
// Ports:
//   i_clk_n / i_rst          : clock (rising edge), synchronous active-high reset
//   i_req_* / o_req_ready    : op request (operands, funct3/7, imm flag, rd tag)
//   i_flush                  : abandon in-flight op and any pending response
//   o_alu_* / i_alu_busy/out : ALU operand/control outputs, busy and result inputs
//   o_rsp_* / i_rsp_ready    : registered result + rd tag with backpressure
//
// Build option: define ALU_SEQ_FAST_PATH_EN to let non-iterative ops capture
// their result in ISSUE and return straight to IDLE.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int RD_W = 5
) (
  input  logic            i_clk_n,
  input  logic            i_rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [31:0]     i_req_a,
  input  logic [31:0]     i_req_b,
  input  logic [2:0]      i_req_funct3,
  input  logic [6:0]      i_req_funct7,
  input  logic            i_req_imm,
  input  logic [RD_W-1:0] i_req_rd,
  input  logic            i_flush,
  output logic [31:0]     o_alu_a,
  output logic [31:0]     o_alu_b,
  output logic [2:0]      o_alu_funct3,
  output logic [6:0]      o_alu_funct7,
  output logic            o_alu_imm,
  output logic            o_alu_en,
  input  logic            i_alu_busy,
  input  logic [31:0]     i_alu_out,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [31:0]     o_rsp_data,
  output logic [RD_W-1:0] o_rsp_rd
);

  seq_state_t      state, state_next;
  logic            req_ready;
  logic            alu_en;
  logic            capture;
  logic            fast_done;
  logic            load;
  logic [RD_W-1:0] op_rd;

`ifdef ALU_SEQ_FAST_PATH_EN
  logic is_iter;

  alu_seq_decode u_decode (
    .funct3       (o_alu_funct3),
    .funct7       (o_alu_funct7),
    .imm          (o_alu_imm),
    .is_iterative (is_iter)
  );

  assign fast_done = !is_iter;
`else
  assign fast_done = 1'b0;
`endif

  always_ff @(posedge i_clk_n) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    alu_en     = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        // Busy is checked here because a reset can land mid-iteration and
        // leave the ALU unit still running.
        req_ready = !i_flush && !i_alu_busy && (!o_rsp_valid || i_rsp_ready);
        if (i_req_valid && req_ready) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        alu_en = 1'b1;
        if (i_flush) state_next = S_DRAIN;
        else if (fast_done) begin
          capture    = 1'b1;
          state_next = S_IDLE;
        end else state_next = S_WAIT;
      end
      S_WAIT: begin
        if (i_flush)          state_next = S_DRAIN;
        else if (!i_alu_busy) state_next = S_COLLECT;
      end
      S_COLLECT: begin
        alu_en = 1'b1;
        if (!i_flush) capture = 1'b1;
        state_next = S_DRAIN;
      end
      S_DRAIN: begin
        // The COLLECT enable may restart the iterative unit; wait it out.
        if (!i_alu_busy) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (i_rst) req_ready = 1'b0;
  end

  assign o_req_ready = req_ready;
  assign o_alu_en    = alu_en;
  assign load        = (state == S_IDLE) && i_req_valid && req_ready;

  // Operands are held for the whole op so the ALU sees stable inputs in
  // both enable cycles.
  always_ff @(posedge i_clk_n) begin
    if (i_rst) begin
      o_alu_a      <= '0;
      o_alu_b      <= '0;
      o_alu_funct3 <= '0;
      o_alu_funct7 <= '0;
      o_alu_imm    <= 1'b0;
      op_rd        <= '0;
    end else if (load) begin
      o_alu_a      <= i_req_a;
      o_alu_b      <= i_req_b;
      o_alu_funct3 <= i_req_funct3;
      o_alu_funct7 <= i_req_funct7;
      o_alu_imm    <= i_req_imm;
      op_rd        <= i_req_rd;
    end
  end

  // Flush wins over capture and handshake. Capture never overwrites an
  // unconsumed response because IDLE only accepts when the slot is free.
  always_ff @(posedge i_clk_n) begin
    if (i_rst) begin
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_rd    <= '0;
    end else if (i_flush) begin
      o_rsp_valid <= 1'b0;
    end else if (capture) begin
      o_rsp_valid <= 1'b1;
      o_rsp_data  <= i_alu_out;
      o_rsp_rd    <= op_rd;
    end else if (o_rsp_valid && i_rsp_ready) begin
      o_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: self-checking bench for alu_sequencer with a behavioural
// RV32IM ALU (combinational result, serial-style busy for shift/mul/div).
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a, req_b;
  logic [2:0]  req_f3;
  logic [6:0]  req_f7;
  logic        req_imm;
  logic [4:0]  req_rd;
  logic        flush;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_f3;
  logic [6:0]  alu_f7;
  logic        alu_imm;
  logic        alu_en;
  logic        alu_busy;
  logic [31:0] alu_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

`ifdef ALU_SEQ_FAST_PATH_EN
  localparam int         ADD_LAT = 2;
  localparam logic [5:0] ADD_EN  = 6'b000001;
`else
  localparam int         ADD_LAT = 4;
  localparam logic [5:0] ADD_EN  = 6'b000101;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  rd;
  } exp_t;
  exp_t q[$];

  alu_sequencer #(.RD_W(5)) dut (
    .i_clk_n(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b), .i_req_funct3(req_f3), .i_req_funct7(req_f7),
    .i_req_imm(req_imm), .i_req_rd(req_rd), .i_flush(flush),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_funct3(alu_f3), .o_alu_funct7(alu_f7),
    .o_alu_imm(alu_imm), .o_alu_en(alu_en), .i_alu_busy(alu_busy), .i_alu_out(alu_out),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data), .o_rsp_rd(rsp_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural ALU ----------------
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f3, input logic [6:0] f7, input logic imm);
    logic [63:0] p;
    logic [31:0] r;
    r = '0;
    if (f7 == 7'b0000001 && !imm) begin
      case (f3)
        3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
        3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
        3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; r = p[63:32]; end
        3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
        3'd4: r = (b == 0) ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a
                  : 32'($signed(a) / $signed(b));
        3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
        3'd6: r = (b == 0) ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0
                  : 32'($signed(a) % $signed(b));
        default: r = (b == 0) ? a : a % b;
      endcase
    end else begin
      case (f3)
        3'd0: r = (f7[5] && !imm) ? a - b : a + b;
        3'd1: r = a << b[4:0];
        3'd2: r = {31'b0, $signed(a) < $signed(b)};
        3'd3: r = {31'b0, a < b};
        3'd4: r = a ^ b;
        3'd5: r = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end
    return r;
  endfunction

  function automatic int busy_len(input logic [2:0] f3, input logic [6:0] f7, input logic imm);
    if (f7 == 7'b0000001 && !imm) return (f3[2] ? 8 : 5);
    if (f3 == 3'd1 || f3 == 3'd5) return 3;
    return 0;
  endfunction

  int busy_cnt = 0;
  assign alu_busy = (busy_cnt != 0);
  // Result only meaningful while enabled and idle; poison it otherwise.
  assign alu_out = (alu_en && !alu_busy) ? alu_f(alu_a, alu_b, alu_f3, alu_f7, alu_imm) : 32'hDEADBEEF;

  // The ALU is not reset with the sequencer.
  always @(posedge clk) begin
    if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    else if (alu_en)   busy_cnt <= busy_len(alu_f3, alu_f7, alu_imm);
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp got data=%h rd=%0d with nothing expected", rsp_data, rsp_rd);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (rsp_data !== e.d || rsp_rd !== e.rd) begin
          failures++;
          $display("FAIL rsp got data=%h rd=%0d expected data=%h rd=%0d", rsp_data, rsp_rd, e.d, e.rd);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                      input logic [6:0] f7, input logic imm, input logic [4:0] rd,
                      input logic [31:0] exp_d, input bit push, output int hcyc);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_a = a; req_b = b; req_f3 = f3; req_f7 = f7; req_imm = imm; req_rd = rd;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    hcyc = cyc;
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL req_timeout ready stayed 0 for %0d cycles, expected 1", n);
    end else if (push) q.push_back('{d: exp_d, rd: rd});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q.size() != 0 || !req_ready) && n < 300) begin @(negedge clk); n++; end
    checks++;
    if (q.size() != 0 || !req_ready) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d ready=%b, expected 0 pending and ready=1", q.size(), req_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    req_a = '0; req_b = '0; req_f3 = '0; req_f7 = '0; req_imm = 1'b0; req_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || alu_en !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl got valid=%b en=%b ready=%b expected 0 0 0", rsp_valid, alu_en, req_ready);
    end
    checks++;
    if ({alu_a, alu_b, alu_f3, alu_f7, alu_imm, rsp_data, rsp_rd} !== '0) begin
      failures++;
      $display("FAIL reset_data got a=%h b=%h f3=%h f7=%h d=%h rd=%h expected all 0",
               alu_a, alu_b, alu_f3, alu_f7, rsp_data, rsp_rd);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release ready=%b expected 1", req_ready);
    end
  endtask

  task automatic test_add();
    int h, lat;
    logic [5:0] en_seen;
    lat = -1; en_seen = '0;
    send(32'd5, 32'd7, 3'b000, 7'b0000000, 1'b0, 5'd3, 32'd12, 1'b1, h);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      en_seen[k] = alu_en;
      if (rsp_valid && lat < 0) lat = cyc - h;
    end
    checks++;
    if (lat != ADD_LAT) begin
      failures++;
      $display("FAIL add_latency got %0d expected %0d", lat, ADD_LAT);
    end
    checks++;
    if (en_seen !== ADD_EN) begin
      failures++;
      $display("FAIL add_enable_pattern got %b expected %b", en_seen, ADD_EN);
    end
    wait_done();
  endtask

  task automatic test_shift();
    logic [31:0] exp_v[2] = '{32'hF8000000, 32'h08000000};
    logic [6:0]  f7v[2]   = '{7'b0100000, 7'b0000000};
    for (int s = 0; s < 2; s++) begin
      int h, n;
      bit early;
      early = 1'b0; n = 0;
      send(32'h80000000, 32'd4, 3'b101, f7v[s], 1'b0, 5'(10 + s), exp_v[s], 1'b1, h);
      // Ready must stay low through ISSUE/WAIT/COLLECT/DRAIN.
      do begin
        @(negedge clk); n++;
        if (req_ready && (n < 4 || alu_busy)) early = 1'b1;
      end while (!req_ready && n < 100);
      checks++;
      if (early || !req_ready) begin
        failures++;
        $display("FAIL shift_ready s=%0d early=%b ready=%b after %0d cycles, expected late ready", s, early, req_ready, n);
      end
    end
    wait_done();
  endtask

  task automatic test_muldiv();
    int h;
    send(32'd100, 32'd7, 3'b100, 7'b0000001, 1'b0, 5'd20, 32'd14, 1'b1, h);
    send(32'd100, 32'd7, 3'b110, 7'b0000001, 1'b0, 5'd21, 32'd2, 1'b1, h);
    send(32'hFFFFFF9C, 32'd7, 3'b100, 7'b0000001, 1'b0, 5'd22, 32'hFFFFFFF2, 1'b1, h);
    send(32'h00010000, 32'h00010000, 3'b011, 7'b0000001, 1'b0, 5'd23, 32'd1, 1'b1, h);
    wait_done();
  endtask

  task automatic test_backpressure();
    int h, n;
    bit stable;
    rsp_ready = 1'b0; n = 0; stable = 1'b1;
    send(32'd2, 32'd3, 3'b000, 7'b0000000, 1'b0, 5'd9, 32'd5, 1'b1, h);
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_a = 32'd1; req_b = 32'd1; req_f3 = 3'b100; req_f7 = '0; req_rd = 5'd30;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== 32'd5 || rsp_rd !== 5'd9 || req_ready) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL bp_hold got valid=%b data=%h rd=%0d ready=%b expected 1 00000005 9 0",
               rsp_valid, rsp_data, rsp_rd, req_ready);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    send(32'd10, 32'd20, 3'b000, 7'b0000000, 1'b0, 5'd4, 32'd30, 1'b1, h);
    wait_done();
  endtask

  task automatic test_flush();
    int h, n;
    bit bad_rsp, bad_ready;
    bad_rsp = 1'b0; bad_ready = 1'b0; n = 0;
    send(32'd100, 32'd7, 3'b100, 7'b0000001, 1'b0, 5'd15, 32'd0, 1'b0, h);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (!alu_busy) begin
      failures++;
      $display("FAIL flush_setup alu_busy=%b expected 1 during WAIT", alu_busy);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    while (n < 40) begin
      @(negedge clk); n++;
      if (rsp_valid) bad_rsp = 1'b1;
      if (req_ready && alu_busy) bad_ready = 1'b1;
    end
    checks++;
    if (bad_rsp || bad_ready) begin
      failures++;
      $display("FAIL flush_quiet rsp_seen=%b ready_while_busy=%b expected 0 0", bad_rsp, bad_ready);
    end
    send(32'd1, 32'd1, 3'b000, 7'b0000000, 1'b0, 5'd6, 32'd2, 1'b1, h);
    wait_done();
  endtask

  task automatic test_reset_mid();
    int h, n;
    bit bad_ready;
    bad_ready = 1'b0; n = 0;
    send(32'd100, 32'd7, 3'b100, 7'b0000001, 1'b0, 5'd17, 32'd0, 1'b0, h);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, alu_en, req_ready, alu_a, alu_b, alu_f3, alu_f7, alu_imm, rsp_data, rsp_rd} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs got valid=%b en=%b ready=%b a=%h b=%h f3=%h f7=%h d=%h rd=%h expected all 0",
               rsp_valid, alu_en, req_ready, alu_a, alu_b, alu_f3, alu_f7, rsp_data, rsp_rd);
    end
    checks++;
    if (!alu_busy) begin
      failures++;
      $display("FAIL rst_mid_busy alu_busy=%b expected 1", alu_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    while (alu_busy && n < 50) begin
      @(negedge clk); n++;
      if (req_ready && alu_busy) bad_ready = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (bad_ready || !req_ready) begin
      failures++;
      $display("FAIL rst_mid_ready ready_while_busy=%b ready_after=%b expected 0 1", bad_ready, req_ready);
    end
    send(32'd7, 32'd8, 3'b000, 7'b0000000, 1'b0, 5'd2, 32'd15, 1'b1, h);
    wait_done();
  endtask

  task automatic test_back_to_back();
    int h;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b, e;
      logic [2:0]  f3;
      logic [6:0]  f7;
      a = $urandom; b = $urandom; f7 = '0;
      case (i % 4)
        0: begin f3 = 3'b000; e = a + b; end
        1: begin f3 = 3'b000; f7 = 7'b0100000; e = a - b; end
        2: begin f3 = 3'b100; e = a ^ b; end
        default: begin f3 = 3'b011; e = {31'b0, a < b}; end
      endcase
      send(a, b, f3, f7, 1'b0, 5'(i), e, 1'b1, h);
    end
    wait_done();
  endtask

  initial begin
    test_reset();
    test_add();
    test_shift();
    test_muldiv();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
